serialtopara: RTL
=================

Name: serialtopara

Overview:
- Two-lane serial-to-parallel deserializer: receiving end of the dual-lane serial link driven by the paratoserial transmitter.
- Each lane recovers byte alignment from comma symbols and assembles DATA_SIZE-bit words, MSB first.
- Pushes non-comma words into a downstream per-lane FIFO.
- Single fast bit clock; a word strobe is produced internally every DATA_SIZE clocks once the lane is aligned.

Parameters:
- DATA_SIZE, 8, word width and bits per serial symbol.
- COMMA, 8'hBC, idle/alignment symbol. Never pushed.
- SYNC_COUNT, 4, consecutive aligned commas required to enter ACTIVE (range 2..7).

Ports:
- clk  in  1  bit clock, one serial bit sampled per rising edge.
- reset  in  1  synchronous, active-high.
- in0  in  1  serial data, lane 0, MSB first.
- in1  in  1  serial data, lane 1, MSB first.
- fifo_almostfull0  in  1  lane-0 downstream FIFO almost full.
- fifo_almostfull1  in  1  lane-1 downstream FIFO almost full.
- out0  out  DATA_SIZE  recovered word, lane 0.
- out1  out  DATA_SIZE  recovered word, lane 1.
- push_0  out  1  one-cycle write strobe for out0.
- push_1  out  1  one-cycle write strobe for out1.
- active_0  out  1  lane 0 aligned.
- active_1  out  1  lane 1 aligned.
- overflow_0  out  1  sticky: lane-0 word dropped due to almost full.
- overflow_1  out  1  sticky: lane-1 word dropped due to almost full.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Lanes: the two lanes are fully independent. Rules below apply per lane.
- Reset state: all outputs 0. State SEARCH. Shift reg = 0, bit_cnt = 0, comma_cnt = 0.
- Shift: every clk edge, sr <= {sr[DATA_SIZE-2:0], in}. Define sr_next = {sr[DATA_SIZE-2:0], in}.
- Boundary: an edge where bit_cnt == DATA_SIZE-1 (outside SEARCH). bit_cnt increments mod DATA_SIZE on every edge outside SEARCH.
- SEARCH (bit-level sliding window):
  - sr_next == COMMA -> ALIGN, comma_cnt = 1, bit_cnt = 0. The next sampled bit is the MSB of the next word.
- ALIGN, at each boundary:
  - sr_next == COMMA: comma_cnt + 1. If that reaches SYNC_COUNT -> ACTIVE, active = 1 from the next cycle.
  - Otherwise -> SEARCH, comma_cnt = 0.
- ACTIVE, at each boundary:
  - out <= sr_next.
  - push <= 1 only if sr_next != COMMA and fifo_almostfull == 0.
  - Non-comma word with fifo_almostfull == 1: push stays 0, overflow <= 1 (sticky until reset).
  - Comma words are idle: no push, no overflow, out still updated.
- ACTIVE persists until reset. No loss-of-sync detection.
- Latency and strobe:
  - push rises the cycle after the edge that samples the word's last bit.
  - push is high exactly 1 cycle; it is 0 on every non-boundary cycle.
  - out holds its value between boundaries.
- Back-pressure: the serial stream cannot be stalled. Words are dropped, never delayed.
- Reset mid-word or mid-ACTIVE: next cycle all outputs 0, state SEARCH. Full re-synchronisation (SYNC_COUNT commas) is required.
- Simultaneous events:
  - Reset has priority over everything.
  - fifo_almostfull is sampled only on the boundary edge.
- Widths: bit_cnt is clog2(DATA_SIZE) bits; comma_cnt is 3 bits.

Decomposition:
- Shared package/defines: COMMA, SYNC_COUNT, DATA_SIZE default, state encodings SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2.
- One sub-module, serial_a_paralelo: a single lane (shift reg, counters, FSM, push/overflow).
- serialtopara instantiates it twice and wires lane ports.

Test Plan:
- Lock and push:
  - Stimulus: reset, then 4x 0xBC then 0x5A on in0, MSB first.
  - Required: active_0 = 1 the cycle after the 4th comma's last bit. push_0 high 1 cycle, 8 clocks later, with out0 = 0x5A.
  - Required: 0 pushes for the commas.
- Insufficient commas:
  - Stimulus: 3x 0xBC then 0x5A, 0x3C.
  - Required: active_0 stays 0, push_0 never asserts.
- Misaligned start:
  - Stimulus: 3 random bits (1,0,1), then 4x 0xBC, then 0xA5.
  - Required: lock achieved, out0 = 0xA5 pushed once.
- Idle and back-pressure:
  - Stimulus: while ACTIVE send 0x11, 0xBC, 0x22. Hold fifo_almostfull0 = 1 during 0x22.
  - Required: one push (0x11). No push for 0xBC. 0x22 dropped, overflow_0 = 1 and stays 1.
- Lane independence:
  - Stimulus: lane 1 aligned with 4x 0xBC, 0x77; lane 0 fed 0xFF only.
  - Required: push_1 once with out1 = 0x77. active_0 = 0, push_0 = 0.
- Reset mid-ACTIVE:
  - Stimulus: assert reset during bit 3 of a data word.
  - Required: all outputs 0 next cycle. A following 0x5A without commas is not pushed; after 4 commas it is.

Source files
------------

// File: rtl/serialtopara_pkg.sv
// Shared definitions for the dual-lane deserializer: default word width,
// comma symbol, lock threshold and per-lane state encoding.
package serialtopara_pkg;

    localparam int         DATA_SIZE_DEF  = 8;
    localparam logic [7:0] COMMA_DEF      = 8'hBC;
    localparam int         SYNC_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } lane_state_t;

endpackage

// File: rtl/serial_a_paralelo.sv
// One deserializer lane: comma-based byte alignment, MSB-first word assembly,
// push to a downstream FIFO with sticky overflow when it is almost full.
module serial_a_paralelo
    import serialtopara_pkg::*;
#(
    parameter int                   DATA_SIZE  = DATA_SIZE_DEF,
    parameter logic [DATA_SIZE-1:0] COMMA      = DATA_SIZE'(COMMA_DEF),
    parameter int                   SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sdata,
    input  logic                 fifo_almostfull,
    output logic [DATA_SIZE-1:0] out,
    output logic                 push,
    output logic                 active,
    output logic                 overflow
);

    localparam int CW = $clog2(DATA_SIZE);

    lane_state_t          state_reg, state_next;
    logic [DATA_SIZE-1:0] sr_reg;
    logic [DATA_SIZE-1:0] sr_next;
    logic [CW-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [2:0]           comma_cnt_reg, comma_cnt_next;
    logic [2:0]           comma_cnt_inc;
    logic [DATA_SIZE-1:0] out_reg, out_next;
    logic                 push_reg, push_next;
    logic                 overflow_reg, overflow_next;
    logic                 boundary;
    logic                 is_comma;

    assign sr_next       = {sr_reg[DATA_SIZE-2:0], sdata};
    assign boundary      = (bit_cnt_reg == CW'(DATA_SIZE - 1));
    assign is_comma      = (sr_next == COMMA);
    assign comma_cnt_inc = comma_cnt_reg + 3'd1;

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        comma_cnt_next = comma_cnt_reg;
        out_next       = out_reg;
        push_next      = 1'b0;
        overflow_next  = overflow_reg;

        // Word phase only runs once a comma has fixed the byte alignment.
        if (state_reg != SEARCH) begin
            bit_cnt_next = boundary ? '0 : bit_cnt_reg + 1'b1;
        end

        unique case (state_reg)
            SEARCH: begin
                if (is_comma) begin
                    state_next     = ALIGN;
                    comma_cnt_next = 3'd1;
                    bit_cnt_next   = '0;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_next = comma_cnt_inc;
                        if (comma_cnt_inc == 3'(SYNC_COUNT)) begin
                            state_next = ACTIVE;
                        end
                    end else begin
                        state_next     = SEARCH;
                        comma_cnt_next = 3'd0;
                    end
                end
            end
            ACTIVE: begin
                // The stream cannot stall: a word hitting a full FIFO is lost.
                if (boundary) begin
                    out_next = sr_next;
                    if (!is_comma) begin
                        if (fifo_almostfull) begin
                            overflow_next = 1'b1;
                        end else begin
                            push_next = 1'b1;
                        end
                    end
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SEARCH;
            sr_reg        <= '0;
            bit_cnt_reg   <= '0;
            comma_cnt_reg <= 3'd0;
            out_reg       <= '0;
            push_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            bit_cnt_reg   <= bit_cnt_next;
            comma_cnt_reg <= comma_cnt_next;
            out_reg       <= out_next;
            push_reg      <= push_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign out      = out_reg;
    assign push     = push_reg;
    assign active   = (state_reg == ACTIVE);
    assign overflow = overflow_reg;

endmodule

// File: rtl/serialtopara.sv
// Two independent deserializer lanes sharing one bit clock; receiving end of
// the dual-lane paratoserial link.
module serialtopara
    import serialtopara_pkg::*;
#(
    parameter int                   DATA_SIZE  = DATA_SIZE_DEF,
    parameter logic [DATA_SIZE-1:0] COMMA      = DATA_SIZE'(COMMA_DEF),
    parameter int                   SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in0,
    input  logic                 in1,
    input  logic                 fifo_almostfull0,
    input  logic                 fifo_almostfull1,
    output logic [DATA_SIZE-1:0] out0,
    output logic [DATA_SIZE-1:0] out1,
    output logic                 push_0,
    output logic                 push_1,
    output logic                 active_0,
    output logic                 active_1,
    output logic                 overflow_0,
    output logic                 overflow_1
);

    logic [1:0]           lane_in;
    logic [1:0]           lane_afull;
    logic [DATA_SIZE-1:0] lane_out [2];
    logic [1:0]           lane_push;
    logic [1:0]           lane_active;
    logic [1:0]           lane_overflow;

    assign lane_in    = {in1, in0};
    assign lane_afull = {fifo_almostfull1, fifo_almostfull0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            serial_a_paralelo #(
                .DATA_SIZE  (DATA_SIZE),
                .COMMA      (COMMA),
                .SYNC_COUNT (SYNC_COUNT)
            ) u_lane (
                .clk             (clk),
                .reset           (reset),
                .sdata           (lane_in[gi]),
                .fifo_almostfull (lane_afull[gi]),
                .out             (lane_out[gi]),
                .push            (lane_push[gi]),
                .active          (lane_active[gi]),
                .overflow        (lane_overflow[gi])
            );
        end
    endgenerate

    assign out0       = lane_out[0];
    assign out1       = lane_out[1];
    assign push_0     = lane_push[0];
    assign push_1     = lane_push[1];
    assign active_0   = lane_active[0];
    assign active_1   = lane_active[1];
    assign overflow_0 = lane_overflow[0];
    assign overflow_1 = lane_overflow[1];

endmodule
